// File: rtl/z_core_mul_unit_if.sv
// z_core_mul_unit_if: multiply request/response bundle between execute control and the multiplier.
//   multiplicand[31:0] rs1 operand, sampled on start acceptance
//   multiplier[31:0]   rs2 operand, sampled on start acceptance
//   mul_start          request a multiply (honoured only when idle)
//   mul_op[1:0]        00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   mul_done           one-cycle completion pulse
//   mul_running        busy from acceptance until the done cycle
//   mul_result[31:0]   selected product word, held until overwritten
interface z_core_mul_unit_if;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        mul_start;
  logic [1:0]  mul_op;
  logic        mul_done;
  logic        mul_running;
  logic [31:0] mul_result;
  modport master (output multiplicand, multiplier, mul_start, mul_op, input mul_done, mul_running, mul_result);
  modport slave (input multiplicand, multiplier, mul_start, mul_op, output mul_done, mul_running, mul_result);
endinterface

// File: rtl/z_core_mul_unit.sv
// z_core_mul_unit: 32x32 shift-add multiplier for MUL/MULH/MULHSU/MULHU, one multiplier bit per cycle.
//   clk  rising-edge clock
//   rstn asynchronous active-low reset
//   bus  request/response bundle (slave side), see z_core_mul_unit_if
module z_core_mul_unit (
  input logic clk,
  input logic rstn,
  z_core_mul_unit_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  logic [1:0]  r_state;
  logic [1:0]  r_op;
  logic [64:0] r_prod;
  logic [31:0] r_mcand;
  logic [31:0] r_result;
  logic [4:0]  r_count;
  logic        r_a_neg;
  logic        r_b_neg;
  logic        r_done;
  logic        r_running;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [32:0] w_sum;
  logic [64:0] w_acc;
  logic [63:0] w_p;
  assign w_a_neg = bus.multiplicand[31] & (bus.mul_op == 2'b01 | bus.mul_op == 2'b10);
  assign w_b_neg = bus.multiplier[31] & (bus.mul_op == 2'b01);
  // 33-bit sum keeps the carry out of the upper half; MULHU needs it for large operands
  assign w_sum = {1'b0, r_prod[63:32]} + {1'b0, r_mcand};
  assign w_acc = r_prod[0] ? {w_sum, r_prod[31:0]} : r_prod;
  // magnitudes were multiplied, so restore the sign of the full 64-bit product
  assign w_p = (r_a_neg ^ r_b_neg) ? -r_prod[63:0] : r_prod[63:0];
  assign bus.mul_done    = r_done;
  assign bus.mul_running = r_running;
  assign bus.mul_result  = r_result;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_prod    <= '0;
      r_mcand   <= '0;
      r_result  <= '0;
      r_count   <= '0;
      r_a_neg   <= 1'b0;
      r_b_neg   <= 1'b0;
      r_done    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.mul_start) begin
            r_op      <= bus.mul_op;
            r_a_neg   <= w_a_neg;
            r_b_neg   <= w_b_neg;
            r_mcand   <= w_a_neg ? -bus.multiplicand : bus.multiplicand;
            r_prod    <= {33'b0, w_b_neg ? -bus.multiplier : bus.multiplier};
            r_count   <= '0;
            r_running <= 1'b1;
            r_state   <= S_CALC;
          end
        end
        S_CALC: begin
          r_prod  <= {1'b0, w_acc[64:1]};
          r_count <= r_count + 5'd1;
          if (r_count == 5'd31) r_state <= S_RESULT;
        end
        S_RESULT: begin
          r_result <= (r_op == 2'b00) ? w_p[31:0] : w_p[63:32];
          r_state  <= S_DONE;
        end
        default: begin
          r_done    <= 1'b1;
          r_running <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_z_core_mul_unit.sv
// tb_z_core_mul_unit: directed corner cases plus random operations checked against an arithmetic model.
module tb_z_core_mul_unit;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;
  z_core_mul_unit_if bus ();
  z_core_mul_unit dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y, p;
    x = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    y = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p = x * y;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction
  function automatic logic [31:0] pick();
    logic [31:0] c [6];
    c = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};
    return ($urandom_range(3) == 0) ? c[$urandom_range(5)] : $urandom;
  endfunction
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      chk("idle_done", 64'(bus.mul_done), 64'(0));
    end
  endtask
  // starts an op at the next edge (E0) and returns just after E34
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit disturb);
    bit busy_ok;
    busy_ok = 1'b1;
    bus.mul_op = op; bus.multiplicand = a; bus.multiplier = b; bus.mul_start = 1'b1;
    @(posedge clk); #1;
    chk("accept", 64'({bus.mul_running, bus.mul_done}), 64'(2'b10));
    bus.mul_start = 1'b0; bus.multiplicand = $urandom; bus.multiplier = $urandom; bus.mul_op = 2'($urandom);
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk); #1;
      if (!bus.mul_running || bus.mul_done) busy_ok = 1'b0;
      if (disturb && e == 10) begin
        bus.multiplicand = '1; bus.multiplier = '1; bus.mul_op = 2'b11; bus.mul_start = 1'b1;
      end
      if (disturb && e == 11) bus.mul_start = 1'b0;
    end
    chk("busy", 64'(busy_ok), 64'(1));
    @(posedge clk); #1;
    chk("result_e33", 64'({bus.mul_running, bus.mul_done, bus.mul_result}), 64'({2'b10, exp}));
    @(posedge clk); #1;
    chk("done_e34", 64'({bus.mul_running, bus.mul_done, bus.mul_result}), 64'({2'b01, exp}));
  endtask
  initial begin
    bit saw_done;
    logic [1:0] op;
    logic [31:0] a, b;
    bus.mul_start = 1'b0; bus.mul_op = '0; bus.multiplicand = '0; bus.multiplier = '0;
    #12 rstn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      chk("reset_idle", 64'({bus.mul_running, bus.mul_done, bus.mul_result}), 64'(0));
    end
    do_op(2'b00, 32'd7, 32'd6, 32'h2A, 1'b0);
    idle(2);
    do_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    idle(1);
    do_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    do_op(2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0);
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    do_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    do_op(2'b10, 32'h00000002, 32'h80000000, 32'h00000001, 1'b0);
    idle(1);
    do_op(2'b00, 32'd5, 32'd5, 32'h19, 1'b1);
    idle(40);
    // asynchronous reset in the middle of CALC
    bus.mul_op = 2'b11; bus.multiplicand = 32'hDEADBEEF; bus.multiplier = 32'h12345678; bus.mul_start = 1'b1;
    @(posedge clk); #1;
    bus.mul_start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rstn = 1'b0;
    #1 chk("async_reset", 64'({bus.mul_running, bus.mul_done, bus.mul_result}), 64'(0));
    @(negedge clk); rstn = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.mul_done || bus.mul_running) saw_done = 1'b1;
    end
    chk("no_done_after_reset", 64'(saw_done), 64'(0));
    do_op(2'b00, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0);
    do_op(2'b11, 32'h00010000, 32'h00010000, 32'h00000001, 1'b0);
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom);
      a = pick();
      b = pick();
      if ($urandom_range(1) == 1) idle($urandom_range(3, 1));
      do_op(op, a, b, ref_mul(op, a, b), 1'b0);
    end
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
